// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the IF-stage next-PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } pc_state_t;

  localparam int unsigned DEFAULT_STEP = 4;

  // Redirect index width; a single source still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/redir_prio_sel.sv
// Priority encoder over redirect requests (index 0 wins) plus target mux.
module redir_prio_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned NUM_REDIR = 2,
  parameter int unsigned WIDTH     = 32,
  localparam int unsigned IW       = idx_width(NUM_REDIR)
) (
  input  logic [NUM_REDIR-1:0]       valid_i,
  input  logic [NUM_REDIR*WIDTH-1:0] target_i,
  output logic                       any_o,
  output logic [IW-1:0]              idx_o,
  output logic [WIDTH-1:0]           target_o
);

  // NOTE: every output gets a default before the loop; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    target_o = '0;
    // Walk from the lowest priority upward so the last hit is the winner.
    for (int k = int'(NUM_REDIR) - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        any_o    = 1'b1;
        idx_o    = IW'(k);
        target_o = target_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: PC register, prioritised redirects, stall hold and a
// pending-redirect buffer that replays a redirect seen during a stall.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      STEP      = DEFAULT_STEP,
  parameter int unsigned      NUM_REDIR = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stall_i,
  input  logic [NUM_REDIR-1:0]       redir_valid_i,
  input  logic [NUM_REDIR*WIDTH-1:0] redir_target_i,
  output logic [WIDTH-1:0]           pc_o,
  output logic                       pc_valid_o,
  output logic                       flush_o,
  output logic                       pend_o
);

  localparam int unsigned      IW     = idx_width(NUM_REDIR);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_state_t        state;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             pend;
  logic [WIDTH-1:0] pend_target;
  logic [IW-1:0]    pend_idx;

  logic             sel_any;
  logic [IW-1:0]    sel_idx;
  logic [WIDTH-1:0] sel_target;

  redir_prio_sel #(
    .NUM_REDIR (NUM_REDIR),
    .WIDTH     (WIDTH)
  ) u_sel (
    .valid_i  (redir_valid_i),
    .target_i (redir_target_i),
    .any_o    (sel_any),
    .idx_o    (sel_idx),
    .target_o (sel_target)
  );

  // While pending, an equal-or-higher-priority request overwrites the buffer;
  // the winner is what gets stored or loaded this cycle.
  logic             replace;
  logic [WIDTH-1:0] win_target;
  logic [IW-1:0]    win_idx;

  assign replace    = sel_any && (sel_idx <= pend_idx);
  assign win_target = replace ? sel_target : pend_target;
  assign win_idx    = replace ? sel_idx    : pend_idx;

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      pend        <= 1'b0;
      pend_target <= '0;
      pend_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        RUN: begin
          if (sel_any) begin
            if (!stall_i) begin
              pc <= sel_target;
            end else begin
              pend_target <= sel_target;
              pend_idx    <= sel_idx;
              pend        <= 1'b1;
              state       <= PEND;
            end
          end else if (!stall_i) begin
            pc <= pc + STEP_W;
          end
        end
        PEND: begin
          if (!stall_i) begin
            pc    <= win_target;
            pend  <= 1'b0;
            state <= RUN;
          end else begin
            pend_target <= win_target;
            pend_idx    <= win_idx;
          end
        end
        default: begin
          state    <= IDLE;
          pc       <= RESET_PC;
          pc_valid <= 1'b0;
          pend     <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o    = !rst_i && !stall_i &&
                      (((state == RUN) && sel_any) || (state == PEND));
  assign pc_o       = pc;
  assign pc_valid_o = pc_valid;
  assign pend_o     = pend;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: fetch sequence, priority, stall/pending replay,
// wrap-around on an 8-bit instance and reset during a pending redirect.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic [1:0]  redir_valid;
  logic [63:0] redir_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        pend;

  logic        start8;
  logic [1:0]  redir_valid8;
  logic [15:0] redir_target8;
  logic [7:0]  pc8;
  logic        pc_valid8;
  logic        flush8;
  logic        pend8;

  int checks   = 0;
  int failures = 0;

  pc_gen #(.WIDTH(32), .RESET_PC(32'h0), .STEP(4), .NUM_REDIR(2)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stall_i        (stall),
    .redir_valid_i  (redir_valid),
    .redir_target_i (redir_target),
    .pc_o           (pc),
    .pc_valid_o     (pc_valid),
    .flush_o        (flush),
    .pend_o         (pend)
  );

  pc_gen #(.WIDTH(8), .RESET_PC(8'h0), .STEP(4), .NUM_REDIR(2)) u_dut8 (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start8),
    .stall_i        (1'b0),
    .redir_valid_i  (redir_valid8),
    .redir_target_i (redir_target8),
    .pc_o           (pc8),
    .pc_valid_o     (pc_valid8),
    .flush_o        (flush8),
    .pend_o         (pend8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_redir();
    redir_valid  = 2'b00;
    redir_target = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; clear_redir();
    start8 = 1'b0; redir_valid8 = 2'b00; redir_target8 = '0;

    // Reset for two cycles
    tick(); tick();
    mid();
    check("reset_pc",    pc,              32'h0);
    check("reset_valid", 32'(pc_valid),   32'd0);
    check("reset_pend",  32'(pend),       32'd0);
    check("reset_flush", 32'(flush),      32'd0);
    tick();
    rst = 1'b0;

    // Redirects in IDLE are ignored
    redir_valid = 2'b01; redir_target[31:0] = 32'h900;
    mid();
    check("idle_flush", 32'(flush), 32'd0);
    tick();
    clear_redir();
    mid();
    check("idle_pc",    pc,            32'h0);
    check("idle_valid", 32'(pc_valid), 32'd0);

    // Start: first fetch at RESET_PC, then sequential
    start = 1'b1;
    tick();
    start = 1'b0;
    mid();
    check("start_pc0",    pc,            32'h0);
    check("start_valid",  32'(pc_valid), 32'd1);
    tick(); mid(); check("seq_pc4", pc, 32'h4);
    tick(); mid(); check("seq_pc8", pc, 32'h8);

    // Single redirect from source 1
    redir_valid = 2'b10; redir_target[63:32] = 32'h40;
    mid();
    check("redir1_flush", 32'(flush), 32'd1);
    tick();
    clear_redir();
    mid();
    check("redir1_pc",      pc,         32'h40);
    check("redir1_noflush", 32'(flush), 32'd0);
    tick(); mid(); check("redir1_seq", pc, 32'h44);

    // Both sources: index 0 wins
    redir_valid = 2'b11; redir_target = {32'h40, 32'h100};
    mid();
    check("prio_flush", 32'(flush), 32'd1);
    tick();
    clear_redir();
    mid();
    check("prio_pc", pc, 32'h100);

    // Stall in RUN without redirect holds pc
    stall = 1'b1;
    tick(); mid(); check("stall_hold", pc, 32'h100);
    stall = 1'b0;

    // Move to 0x10, then redirect during a 3-cycle stall
    redir_valid = 2'b01; redir_target[31:0] = 32'h10;
    tick();
    clear_redir();
    stall = 1'b1; redir_valid = 2'b10; redir_target[63:32] = 32'h80;
    mid();
    check("stallredir_flush", 32'(flush), 32'd0);
    check("stallredir_pc",    pc,         32'h10);
    tick();
    clear_redir();
    mid();
    check("pend_set",   32'(pend),     32'd1);
    check("pend_pc",    pc,            32'h10);
    check("pend_flush", 32'(flush),    32'd0);
    check("pend_valid", 32'(pc_valid), 32'd1);
    tick();
    mid();
    check("pend_hold_pc", pc, 32'h10);
    tick();
    stall = 1'b0;
    mid();
    check("release_flush", 32'(flush), 32'd1);
    tick();
    mid();
    check("release_pc",   pc,        32'h80);
    check("release_pend", 32'(pend), 32'd0);

    // PEND(idx1,0x80) replaced by redir0=0x200; then redir1=0x300 dropped
    stall = 1'b1; redir_valid = 2'b10; redir_target[63:32] = 32'h80;
    tick();
    redir_valid = 2'b01; redir_target = {32'h0, 32'h200};
    tick();
    redir_valid = 2'b10; redir_target = {32'h300, 32'h0};
    tick();
    clear_redir();
    stall = 1'b0;
    mid();
    check("replace_flush", 32'(flush), 32'd1);
    tick();
    mid();
    check("replace_drop_pc", pc, 32'h200);

    // Release with same-cycle higher-priority redirect loads the new target
    stall = 1'b1; redir_valid = 2'b10; redir_target = {32'h500, 32'h0};
    tick();
    stall = 1'b0; redir_valid = 2'b01; redir_target = {32'h0, 32'h600};
    mid();
    check("samecyc_flush", 32'(flush), 32'd1);
    tick();
    clear_redir();
    mid();
    check("samecyc_pc", pc, 32'h600);

    // Reset while pending: flush suppressed, everything back to reset values
    stall = 1'b1; redir_valid = 2'b10; redir_target = {32'h700, 32'h0};
    tick();
    clear_redir();
    mid();
    check("pre_rst_pend", 32'(pend), 32'd1);
    rst = 1'b1; stall = 1'b0;
    mid();
    check("rst_flush", 32'(flush), 32'd0);
    tick();
    mid();
    check("rst_pc",    pc,            32'h0);
    check("rst_pend",  32'(pend),     32'd0);
    check("rst_valid", 32'(pc_valid), 32'd0);
    rst = 1'b0;
    tick(); mid();
    check("rst_idle_pc", pc, 32'h0);

    // 8-bit instance wraps 0xFC -> 0x00
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    redir_valid8 = 2'b01; redir_target8 = {8'h00, 8'hFC};
    tick();
    redir_valid8 = 2'b00;
    mid();
    check("w8_pc_fc", 32'(pc8), 32'hFC);
    tick();
    mid();
    check("w8_wrap", 32'(pc8), 32'h00);
    check("w8_valid", 32'(pc_valid8), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
